key_filter_bank: RTL and testbench

Multi-channel push-button conditioner. It sits between the board's raw active-low key pins and the application logic. Each of NUM_KEYS channels is synchronised, debounced with a MASK_TIME-cycle stability window, and turned into a debounced level plus single-cycle event pulses: press, release, long-press and auto-repeat. It extends the single-key key_filter with a channel count, release events and hold-time modes.

---
 rtl/key_filter_pkg.sv | 11 +
 rtl/key_filter_chan.sv | 76 +++++++
 rtl/key_filter_bank.sv | 35 +++
 tb/tb_key_filter_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// key_filter_pkg: shared hold-FSM state type and counter sizing for the key filter bank
package key_filter_pkg;
  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_e;

  function automatic int cnt_width(input int mask_time, input int long_time, input int repeat_time);
    int m;
    m = mask_time > long_time ? mask_time : long_time;
    m = repeat_time > m ? repeat_time : m;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/key_filter_chan.sv
// key_filter_chan: one key channel - synchroniser, debounce, hold FSM and event pulses
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter int MASK_TIME   = 500000,
  parameter int LONG_TIME   = 50000000,
  parameter int REPEAT_TIME = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int W = cnt_width(MASK_TIME, LONG_TIME, REPEAT_TIME);
  localparam logic [W-1:0] MASK_LAST = W'(MASK_TIME - 1);
  localparam logic [W-1:0] LONG_LAST = W'(LONG_TIME - 1);
  localparam logic [W-1:0] REP_LAST = W'(REPEAT_TIME - 1);
  localparam bit REP_EN = REPEAT_TIME > 0;
  logic [1:0] meta_q, meta_d;
  logic sync_q, sync_d, key_state_q, key_state_d;
  logic press_q, press_d, release_q, release_d, long_q, long_d, repeat_q, repeat_d;
  logic [W-1:0] db_cnt_q, db_cnt_d, hold_cnt_q, hold_cnt_d;
  hold_state_e state_q, state_d;
  logic toggle, fall, hold_hit;
  // sync_q adds a registered inversion stage after the 2-FF synchroniser
  always_comb begin
    meta_d = {meta_q[0], key_n};
    sync_d = ~meta_q[1];
    toggle = (sync_q != key_state_q) && (db_cnt_q == MASK_LAST);
    fall = toggle && key_state_q;
    key_state_d = key_state_q ^ toggle;
    db_cnt_d = (sync_q == key_state_q || toggle) ? '0 : (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + 1'b1;
    press_d = toggle && !key_state_q;
    release_d = fall;
    hold_hit = (state_q == HELD) ? (hold_cnt_q == LONG_LAST) : (state_q == LONG && REP_EN && hold_cnt_q == REP_LAST);
    long_d = (state_q == HELD) && hold_hit && !fall;
    repeat_d = (state_q == LONG) && hold_hit && !fall;
    state_d = fall ? IDLE : press_d ? HELD : long_d ? LONG : state_q;
    hold_cnt_d = (fall || press_d || hold_hit) ? '0 :
                 (state_q != IDLE && key_state_q && hold_cnt_q != '1) ? hold_cnt_q + 1'b1 : hold_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= 2'b11;
      sync_q      <= 1'b0;
      key_state_q <= 1'b0;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      state_q     <= IDLE;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      key_state_q <= key_state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      state_q     <= state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end
  assign key_state     = key_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
endmodule

// File: rtl/key_filter_bank.sv
// key_filter_bank: NUM_KEYS independent debounced push-button channels
module key_filter_bank
  import key_filter_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int MASK_TIME   = 500000,
  parameter int LONG_TIME   = 50000000,
  parameter int REPEAT_TIME = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_filter_chan #(
      .MASK_TIME  (MASK_TIME),
      .LONG_TIME  (LONG_TIME),
      .REPEAT_TIME(REPEAT_TIME)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .key_n        (key_n[i]),
      .key_state    (key_state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end
endmodule

// File: tb/tb_key_filter_bank.sv
// tb_key_filter_bank: directed scenario tests for key_filter_bank (2 keys, MASK=5, LONG=20, REPEAT=8)
module tb_key_filter_bank;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] key_n;
  logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [9:0] obs;
  int passed = 0;
  int total = 0;

  key_filter_bank #(.NUM_KEYS(N), .MASK_TIME(5), .LONG_TIME(20), .REPEAT_TIME(8)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .key_state(key_state), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #10 clk = ~clk;
  assign obs = {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_n = 2'b11;
    #1 rst = 1'b1;
    for (int s = 1; s <= 30; s++) begin
      if (s == 11) rst = 1'b0;
      step();
      total++;
      if (obs !== 10'b0) $display("FAIL reset s=%0d got %b exp %b", s, obs, 10'b0);
      else passed++;
    end
  endtask

  task automatic test_bounce();
    for (int s = 1; s <= 15; s++) begin
      key_n[0] = !(s == 1 || (s >= 3 && s <= 6));
      step();
      total++;
      if (obs !== 10'b0) $display("FAIL bounce s=%0d got %b exp %b", s, obs, 10'b0);
      else passed++;
    end
    key_n[0] = 1'b1;
  endtask

  task automatic test_press_release();
    logic [1:0] ks, pp, rl, lg, rp;
    key_n[0] = 1'b0;
    for (int s = 1; s <= 30; s++) begin
      step();
      ks = {1'b0, s >= 8 && s < 20};
      pp = {1'b0, s == 8};
      rl = {1'b0, s == 20};
      lg = 2'b0;
      rp = 2'b0;
      total++;
      if (obs !== {ks, pp, rl, lg, rp}) $display("FAIL press_release s=%0d got %b exp %b", s, obs, {ks, pp, rl, lg, rp});
      else passed++;
      if (s == 12) key_n[0] = 1'b1;
    end
  endtask

  task automatic test_long_repeat();
    logic [1:0] ks, pp, rl, lg, rp;
    key_n[1] = 1'b0;
    for (int s = 1; s <= 65; s++) begin
      step();
      ks = {s >= 8 && s < 53, 1'b0};
      pp = {s == 8, 1'b0};
      rl = {s == 53, 1'b0};
      lg = {s == 28, 1'b0};
      rp = {s == 36 || s == 44 || s == 52, 1'b0};
      total++;
      if (obs !== {ks, pp, rl, lg, rp}) $display("FAIL long_repeat s=%0d got %b exp %b", s, obs, {ks, pp, rl, lg, rp});
      else passed++;
      if (s == 45) key_n[1] = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ks, pp, rl, lg, rp;
    key_n[0] = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      step();
      ks = {s >= 18 && s < 28, s >= 8 && s < 18};
      pp = {s == 18, s == 8};
      rl = {s == 28, s == 18};
      lg = 2'b0;
      rp = 2'b0;
      total++;
      if (obs !== {ks, pp, rl, lg, rp}) $display("FAIL back_to_back s=%0d got %b exp %b", s, obs, {ks, pp, rl, lg, rp});
      else passed++;
      if (s == 10) key_n = 2'b01;
      if (s == 20) key_n[1] = 1'b1;
    end
  endtask

  task automatic test_release_vs_long();
    logic [1:0] ks, pp, rl, lg, rp;
    key_n[0] = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      step();
      ks = {1'b0, s >= 8 && s < 28};
      pp = {1'b0, s == 8};
      rl = {1'b0, s == 28};
      lg = 2'b0;
      rp = 2'b0;
      total++;
      if (obs !== {ks, pp, rl, lg, rp}) $display("FAIL release_vs_long s=%0d got %b exp %b", s, obs, {ks, pp, rl, lg, rp});
      else passed++;
      if (s == 20) key_n[0] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [1:0] ks, pp, rl, lg, rp;
    key_n[1] = 1'b0;
    for (int s = 1; s <= 18; s++) begin
      step();
      ks = {s >= 8, 1'b0};
      pp = {s == 8, 1'b0};
      total++;
      if (obs !== {ks, pp, 6'b0}) $display("FAIL mid_hold_pre s=%0d got %b exp %b", s, obs, {ks, pp, 6'b0});
      else passed++;
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 10'b0) $display("FAIL mid_hold_async got %b exp %b", obs, 10'b0);
    else passed++;
    for (int s = 1; s <= 2; s++) begin
      step();
      total++;
      if (obs !== 10'b0) $display("FAIL mid_hold_in_reset s=%0d got %b exp %b", s, obs, 10'b0);
      else passed++;
    end
    rst = 1'b0;
    for (int t = 1; t <= 45; t++) begin
      step();
      ks = {t >= 8 && t < 38, 1'b0};
      pp = {t == 8, 1'b0};
      rl = {t == 38, 1'b0};
      lg = {t == 28, 1'b0};
      rp = {t == 36, 1'b0};
      total++;
      if (obs !== {ks, pp, rl, lg, rp}) $display("FAIL mid_hold_post t=%0d got %b exp %b", t, obs, {ks, pp, rl, lg, rp});
      else passed++;
      if (t == 30) key_n[1] = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press_release();
    test_long_repeat();
    test_back_to_back();
    test_release_vs_long();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
